// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard video path.
package billiard_pkg;

    localparam int unsigned RGB_W_DEF        = 8;
    localparam int unsigned NUM_LAYERS_DEF   = 4;
    localparam int unsigned FLASH_FRAMES_DEF = 30;

    typedef logic [RGB_W_DEF-1:0] rgb_t;

    localparam rgb_t BG_DEF          = 8'h00;
    localparam rgb_t TRANSPARENT_DEF = 8'hFF;

    localparam int unsigned LAYER_BORDERS = 0;
    localparam int unsigned LAYER_BALLS   = 1;
    localparam int unsigned LAYER_CUE     = 2;
    localparam int unsigned LAYER_BOARD   = 3;

endpackage

// File: rtl/layer_priority_enc.sv
// Combinational lowest-set-bit encoder: valid flag plus index of the winning request.
module layer_priority_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        valid_c = |req_i;
        idx_c   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage fixed-priority layer compositor with colour keying and per-frame overlap report.
// Optional blink of the last layer: define LAYER_COMPOSITOR_FLASH_EN.
module layer_compositor
    import billiard_pkg::*;
#(
    parameter int unsigned      NUM_LAYERS   = NUM_LAYERS_DEF,
    parameter int unsigned      RGB_W        = RGB_W_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR     = RGB_W'(BG_DEF),
    parameter logic [RGB_W-1:0] TRANSPARENT  = RGB_W'(TRANSPARENT_DEF),
    parameter int unsigned      FLASH_FRAMES = FLASH_FRAMES_DEF
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic [NUM_LAYERS-1:0]          drawingRequest,
    input  logic [NUM_LAYERS*RGB_W-1:0]    RGBIn,
    input  logic                           layerEnableWr,
    input  logic [NUM_LAYERS-1:0]          layerEnableIn,
    input  logic                           startOfFrame,
    input  logic                           flashTrig,
    output logic [RGB_W-1:0]               RGBOut,
    output logic [$clog2(NUM_LAYERS)-1:0]  winnerIdx,
    output logic                           anyDraw,
    output logic [NUM_LAYERS-1:0]          overlapFrame,
    output logic                           overlapValid
);

    localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
    localparam int unsigned BUS_W = NUM_LAYERS * RGB_W;

    logic [NUM_LAYERS-1:0] en_mask_q, en_mask_d;
    logic [NUM_LAYERS-1:0] eff_q, eff_d;
    logic [BUS_W-1:0]      rgb_q;
    logic                  sof_q;

    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [NUM_LAYERS-1:0] ovl_frame_q, ovl_frame_d;
    logic                  ovl_valid_q;

    logic [RGB_W-1:0]      rgb_out_q, rgb_out_d;
    logic [IDX_W-1:0]      win_idx_q, win_idx_d;
    logic                  any_q, any_d;

    logic                  win_valid_c;
    logic [IDX_W-1:0]      win_idx_c;
    logic [NUM_LAYERS-1:0] rest_req_c;
    logic                  second_valid_c;
    logic [IDX_W-1:0]      unused_second_idx_c;
    logic [NUM_LAYERS-1:0] contrib_c;
    logic [RGB_W-1:0]      win_rgb_c;
    logic [RGB_W-1:0]      pix_rgb_c;

    // Stage 1 qualify: request, runtime enable and colour key.
    always_comb begin
        eff_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff_d[i] = drawingRequest[i] & en_mask_q[i]
                     & (RGBIn[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
        en_mask_d = layerEnableWr ? layerEnableIn : en_mask_q;
    end

    layer_priority_enc #(
        .N     (NUM_LAYERS),
        .IDX_W (IDX_W)
    ) u_win_enc (
        .req_i   (eff_q),
        .valid_c (win_valid_c),
        .idx_c   (win_idx_c)
    );

    // A second layer still drawing once the winner is removed means two or more overlap.
    assign rest_req_c = eff_q & ~(NUM_LAYERS'(1) << win_idx_c);

    layer_priority_enc #(
        .N     (NUM_LAYERS),
        .IDX_W (IDX_W)
    ) u_second_enc (
        .req_i   (rest_req_c),
        .valid_c (second_valid_c),
        .idx_c   (unused_second_idx_c)
    );

    always_comb begin
        contrib_c   = second_valid_c ? eff_q : '0;
        acc_d       = sof_q ? contrib_c : (acc_q | contrib_c);
        ovl_frame_d = sof_q ? acc_q : ovl_frame_q;
    end

    always_comb begin
        win_rgb_c = BG_COLOR;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (win_valid_c && (win_idx_c == IDX_W'(i))) begin
                win_rgb_c = rgb_q[i*RGB_W +: RGB_W];
            end
        end
    end

`ifdef LAYER_COMPOSITOR_FLASH_EN
    // Counter needs bit 3 for the 8-on/8-off blink even for short flashes.
    localparam int unsigned FC_W = ($clog2(FLASH_FRAMES + 1) > 4) ? $clog2(FLASH_FRAMES + 1) : 4;

    logic [FC_W-1:0] flash_cnt_q, flash_cnt_d;
    logic            flash_on_c;

    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (flashTrig) begin
            flash_cnt_d = FC_W'(FLASH_FRAMES);
        end else if (sof_q && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - FC_W'(1);
        end
        flash_on_c = (flash_cnt_q != '0) && flash_cnt_q[3];
        pix_rgb_c  = (flash_on_c && win_valid_c && (win_idx_c == IDX_W'(NUM_LAYERS - 1)))
                   ? ~win_rgb_c : win_rgb_c;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            flash_cnt_q <= '0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
        end
    end
`else
    logic [31:0] unused_flash_c;

    assign unused_flash_c = 32'(FLASH_FRAMES) ^ {31'd0, flashTrig};
    assign pix_rgb_c      = win_rgb_c;
`endif

    always_comb begin
        rgb_out_d = pix_rgb_c;
        win_idx_d = win_valid_c ? win_idx_c : '0;
        any_d     = win_valid_c;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            en_mask_q   <= '1;
            eff_q       <= '0;
            rgb_q       <= '0;
            sof_q       <= 1'b0;
            acc_q       <= '0;
            ovl_frame_q <= '0;
            ovl_valid_q <= 1'b0;
            rgb_out_q   <= BG_COLOR;
            win_idx_q   <= '0;
            any_q       <= 1'b0;
        end else begin
            en_mask_q   <= en_mask_d;
            eff_q       <= eff_d;
            rgb_q       <= RGBIn;
            sof_q       <= startOfFrame;
            acc_q       <= acc_d;
            ovl_frame_q <= ovl_frame_d;
            ovl_valid_q <= sof_q;
            rgb_out_q   <= rgb_out_d;
            win_idx_q   <= win_idx_d;
            any_q       <= any_d;
        end
    end

    assign RGBOut       = rgb_out_q;
    assign winnerIdx    = win_idx_q;
    assign anyDraw      = any_q;
    assign overlapFrame = ovl_frame_q;
    assign overlapValid = ovl_valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: directed pixels and frame pulses, monitor checks outputs.
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  drawingRequest;
    logic [31:0] RGBIn;
    logic        layerEnableWr;
    logic [3:0]  layerEnableIn;
    logic        startOfFrame;
    logic        flashTrig;
    logic [7:0]  RGBOut;
    logic [1:0]  winnerIdx;
    logic        anyDraw;
    logic [3:0]  overlapFrame;
    logic        overlapValid;

    layer_compositor dut (
        .clk            (clk),
        .resetN         (resetN),
        .drawingRequest (drawingRequest),
        .RGBIn          (RGBIn),
        .layerEnableWr  (layerEnableWr),
        .layerEnableIn  (layerEnableIn),
        .startOfFrame   (startOfFrame),
        .flashTrig      (flashTrig),
        .RGBOut         (RGBOut),
        .winnerIdx      (winnerIdx),
        .anyDraw        (anyDraw),
        .overlapFrame   (overlapFrame),
        .overlapValid   (overlapValid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned stamp;
        logic [7:0]  rgb;
        logic [1:0]  idx;
        logic        any;
    } pix_exp_t;

    typedef struct {
        int unsigned stamp;
        logic [3:0]  val;
    } ovl_exp_t;

    pix_exp_t pq[$];
    ovl_exp_t oq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one pixel on the falling edge and queue its expected result.
    task automatic pix(input logic [3:0] req, input logic [31:0] rgb, input logic sof,
                       input logic [3:0] exp_ovl, input logic [7:0] exp_rgb,
                       input logic [1:0] exp_idx, input logic exp_any);
        pix_exp_t e;
        ovl_exp_t o;
        @(negedge clk);
        drawingRequest = req;
        RGBIn          = rgb;
        startOfFrame   = sof;
        layerEnableWr  = 1'b0;
        flashTrig      = 1'b0;
        e.stamp = cyc; e.rgb = exp_rgb; e.idx = exp_idx; e.any = exp_any;
        pq.push_back(e);
        if (sof) begin
            o.stamp = cyc; o.val = exp_ovl;
            oq.push_back(o);
        end
    endtask

    task automatic idle();
        pix(4'b0000, 32'h0, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    endtask

    task automatic sof_idle(input logic [3:0] exp_ovl);
        pix(4'b0000, 32'h0, 1'b1, exp_ovl, 8'h00, 2'd0, 1'b0);
    endtask

    task automatic set_en(input logic [3:0] mask);
        idle();
        layerEnableWr = 1'b1;
        layerEnableIn = mask;
    endtask

    task automatic trig();
        idle();
        flashTrig = 1'b1;
    endtask

    // Monitor: compares outputs two cycles after each queued stimulus.
    initial forever begin
        pix_exp_t e;
        ovl_exp_t o;
        @(negedge clk);
        if (pq.size() > 0 && pq[0].stamp + 2 == cyc) begin
            e = pq.pop_front();
            check("rgb_out", 32'(RGBOut), 32'(e.rgb));
            check("winner_idx", 32'(winnerIdx), 32'(e.idx));
            check("any_draw", 32'(anyDraw), 32'(e.any));
        end
        if (oq.size() > 0 && oq[0].stamp + 2 == cyc) begin
            o = oq.pop_front();
            check("ovl_valid", 32'(overlapValid), 32'd1);
            check("ovl_frame", 32'(overlapFrame), 32'(o.val));
        end else if (overlapValid) begin
            check("ovl_spurious", 32'(overlapValid), 32'd0);
        end
    end

    initial begin
        resetN = 1'b0; drawingRequest = '0; RGBIn = '0; layerEnableWr = 1'b0;
        layerEnableIn = '0; startOfFrame = 1'b0; flashTrig = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(RGBOut), 32'h00);
        check("rst_idx", 32'(winnerIdx), 32'd0);
        check("rst_any", 32'(anyDraw), 32'd0);
        check("rst_ovl_frame", 32'(overlapFrame), 32'd0);
        check("rst_ovl_valid", 32'(overlapValid), 32'd0);
        resetN = 1'b1;

        sof_idle(4'b0000);
        // Priority, colour key, single layer.
        pix(4'b1010, 32'hE0001C00, 1'b0, 4'b0000, 8'h1C, 2'd1, 1'b1);
        pix(4'b0011, 32'h000003FF, 1'b0, 4'b0000, 8'h03, 2'd1, 1'b1);
        pix(4'b0100, 32'h00550000, 1'b0, 4'b0000, 8'h55, 2'd2, 1'b1);
        idle();
        sof_idle(4'b1010);
        pix(4'b0110, 32'h00E31C00, 1'b0, 4'b0000, 8'h1C, 2'd1, 1'b1);
        idle();
        sof_idle(4'b0110);
        idle();
        sof_idle(4'b0000);
        // Pixel on the frame boundary belongs to the new frame.
        pix(4'b1111, 32'h44332211, 1'b1, 4'b0000, 8'h11, 2'd0, 1'b1);
        pix(4'b1001, 32'h200000FF, 1'b0, 4'b0000, 8'h20, 2'd3, 1'b1);
        idle();
        sof_idle(4'b1111);

        set_en(4'b1101);
        pix(4'b0010, 32'h00001C00, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        pix(4'b0011, 32'h00001C07, 1'b0, 4'b0000, 8'h07, 2'd0, 1'b1);
        pix(4'b0110, 32'h00E31C00, 1'b0, 4'b0000, 8'hE3, 2'd2, 1'b1);
        set_en(4'b0000);
        pix(4'b1111, 32'h44332211, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        pix(4'b1111, 32'h44332211, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        set_en(4'b1111);

        // Mid-frame reset discards the accumulated overlap.
        pix(4'b0011, 32'h00001C07, 1'b0, 4'b0000, 8'h07, 2'd0, 1'b1);
        idle();
        idle();
        @(negedge clk);
        resetN = 1'b0; drawingRequest = '0; startOfFrame = 1'b0; layerEnableWr = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_ovl_frame", 32'(overlapFrame), 32'd0);
        check("midrst_any", 32'(anyDraw), 32'd0);
        resetN = 1'b1;
        sof_idle(4'b0000);
        pix(4'b0010, 32'h00001C00, 1'b0, 4'b0000, 8'h1C, 2'd1, 1'b1);
        idle();
        sof_idle(4'b0000);

`ifdef LAYER_COMPOSITOR_FLASH_EN
        trig();
        pix(4'b1000, 32'h0F000000, 1'b0, 4'b0000, 8'hF0, 2'd3, 1'b1);
        pix(4'b0100, 32'h000F0000, 1'b0, 4'b0000, 8'h0F, 2'd2, 1'b1);
        repeat (7) begin sof_idle(4'b0000); idle(); end
        pix(4'b1000, 32'h0F000000, 1'b0, 4'b0000, 8'h0F, 2'd3, 1'b1);
        repeat (8) begin sof_idle(4'b0000); idle(); end
        pix(4'b1000, 32'h0F000000, 1'b0, 4'b0000, 8'hF0, 2'd3, 1'b1);
        repeat (15) begin sof_idle(4'b0000); idle(); end
        pix(4'b1000, 32'h0F000000, 1'b0, 4'b0000, 8'h0F, 2'd3, 1'b1);
`else
        pix(4'b1000, 32'h0F000000, 1'b0, 4'b0000, 8'h0F, 2'd3, 1'b1);
`endif

        repeat (4) idle();
        repeat (3) @(negedge clk);
        check("pix_queue_drained", 32'(pq.size()), 32'd0);
        check("ovl_queue_drained", 32'(oq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
